// File: rtl/alu_result_packer.sv
// Streams each valid ALU result as bytes, LSB first, over a valid/ready byte interface.
// One extra result can be held pending while a transfer is in flight; a third is dropped and flagged.
module alu_result_packer #(
    parameter int OUT_DATA_WIDTH = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [OUT_DATA_WIDTH-1:0] ALU_OUT,
    input  logic                      OUT_VALID,
    output logic [7:0]                TX_DATA,
    output logic                      TX_VLD,
    input  logic                      TX_RDY,
    output logic                      BUSY,
    output logic                      OVERRUN
);

    localparam int BYTES = OUT_DATA_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                    state_reg;
    logic [OUT_DATA_WIDTH-1:0] cur_reg;
    logic [OUT_DATA_WIDTH-1:0] pend_reg;
    logic                      pend_v_reg;
    logic [IDX_W-1:0]          idx_reg;
    logic                      overrun_reg;

    logic [7:0] byte_lane [BYTES];

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            assign byte_lane[gi] = cur_reg[8*gi +: 8];
        end
    endgenerate

    logic handshake;
    logic last_hs;

    assign handshake = (state_reg == SEND) && TX_RDY;
    assign last_hs   = handshake && (idx_reg == LAST_IDX);

    // Outputs decode straight from registered state, so they hold while stalled.
    assign TX_VLD  = (state_reg == SEND);
    assign TX_DATA = byte_lane[idx_reg];
    assign BUSY    = (state_reg == SEND) || pend_v_reg;
    assign OVERRUN = overrun_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= IDLE;
            cur_reg     <= '0;
            pend_reg    <= '0;
            pend_v_reg  <= 1'b0;
            idx_reg     <= '0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (OUT_VALID) begin
                        cur_reg   <= ALU_OUT;
                        idx_reg   <= '0;
                        state_reg <= SEND;
                    end
                end
                SEND: begin
                    if (last_hs) begin
                        if (pend_v_reg) begin
                            // Pending result advances; a new arrival refills the freed slot.
                            cur_reg <= pend_reg;
                            idx_reg <= '0;
                            if (OUT_VALID) begin
                                pend_reg <= ALU_OUT;
                            end else begin
                                pend_v_reg <= 1'b0;
                            end
                        end else if (OUT_VALID) begin
                            cur_reg <= ALU_OUT;
                            idx_reg <= '0;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        if (handshake) begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                        if (OUT_VALID) begin
                            if (!pend_v_reg) begin
                                pend_reg   <= ALU_OUT;
                                pend_v_reg <= 1'b1;
                            end else begin
                                overrun_reg <= 1'b1;
                            end
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_packer.sv
// Bench for alu_result_packer: directed scenarios plus random traffic against a byte-queue model.
module tb_alu_result_packer;

    localparam int W     = 16;
    localparam int BYTES = W / 8;

    logic         CLK;
    logic         RST;
    logic [W-1:0] ALU_OUT;
    logic         OUT_VALID;
    logic [7:0]   TX_DATA;
    logic         TX_VLD;
    logic         TX_RDY;
    logic         BUSY;
    logic         OVERRUN;

    alu_result_packer #(.OUT_DATA_WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ALU_OUT   (ALU_OUT),
        .OUT_VALID (OUT_VALID),
        .TX_DATA   (TX_DATA),
        .TX_VLD    (TX_VLD),
        .TX_RDY    (TX_RDY),
        .BUSY      (BUSY),
        .OVERRUN   (OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model: every byte still owed to the consumer, in order of transmission.
    logic [7:0] exp_q [$];
    logic       exp_ovr;
    logic [7:0] got_q [$];
    logic [7:0] want_q [$];
    int         ovr_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: check outputs, apply inputs, advance the model, step to next negedge.
    task automatic cyc(input logic ov, input logic [W-1:0] d, input logic rdy);
        int  owed;
        logic exp_v;
        exp_v = (exp_q.size() > 0);
        chk("tx_vld", {31'b0, TX_VLD}, {31'b0, exp_v});
        chk("busy", {31'b0, BUSY}, {31'b0, exp_v});
        chk("overrun", {31'b0, OVERRUN}, {31'b0, exp_ovr});
        if (exp_v) chk("tx_data", {24'b0, TX_DATA}, {24'b0, exp_q[0]});
        if (OVERRUN) ovr_cnt++;
        if (TX_VLD && rdy) got_q.push_back(TX_DATA);
        $display("cyc ov=%0b d=%h rdy=%0b | vld=%0b data=%h busy=%0b ovr=%0b",
                 ov, d, rdy, TX_VLD, TX_DATA, BUSY, OVERRUN);

        OUT_VALID = ov;
        ALU_OUT   = d;
        TX_RDY    = rdy;

        if (exp_v && rdy) void'(exp_q.pop_front());
        owed    = (exp_q.size() + BYTES - 1) / BYTES;
        exp_ovr = 1'b0;
        if (ov) begin
            if (owed < 2) begin
                for (int b = 0; b < BYTES; b++) exp_q.push_back(d[8*b +: 8]);
            end else begin
                exp_ovr = 1'b1;
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, "_len"}, got_q.size(), want_q.size());
        for (int i = 0; i < want_q.size() && i < got_q.size(); i++)
            chk(tag, {24'b0, got_q[i]}, {24'b0, want_q[i]});
        got_q.delete();
        ovr_cnt = 0;
    endtask

    initial begin
        RST       = 1'b1;
        OUT_VALID = 1'b0;
        ALU_OUT   = '0;
        TX_RDY    = 1'b0;
        exp_ovr   = 1'b0;
        ovr_cnt   = 0;
        #1;
        chk("rst_data", {24'b0, TX_DATA}, 32'h00);
        chk("rst_vld", {31'b0, TX_VLD}, 32'h0);
        chk("rst_busy", {31'b0, BUSY}, 32'h0);
        chk("rst_ovr", {31'b0, OVERRUN}, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Single result, consumer always ready.
        cyc(1'b1, 16'hA55A, 1'b1);
        repeat (3) cyc(1'b0, 16'h0, 1'b1);
        want_q = '{8'h5A, 8'hA5};
        chk_stream("s1_stream");

        // Stall three cycles on byte 0.
        cyc(1'b1, 16'hA55A, 1'b0);
        repeat (3) cyc(1'b0, 16'h0, 1'b0);
        repeat (3) cyc(1'b0, 16'h0, 1'b1);
        want_q = '{8'h5A, 8'hA5};
        chk_stream("s2_stream");

        // Back-to-back results, no gap.
        cyc(1'b1, 16'h1234, 1'b1);
        cyc(1'b1, 16'h5678, 1'b1);
        repeat (5) cyc(1'b0, 16'h0, 1'b1);
        chk("s3_ovr_cnt", ovr_cnt, 0);
        want_q = '{8'h34, 8'h12, 8'h78, 8'h56};
        chk_stream("s3_stream");

        // Third result while stalled is dropped.
        cyc(1'b1, 16'h0001, 1'b0);
        cyc(1'b1, 16'h0002, 1'b0);
        cyc(1'b1, 16'h0003, 1'b0);
        cyc(1'b0, 16'h0, 1'b0);
        repeat (6) cyc(1'b0, 16'h0, 1'b1);
        chk("s4_ovr_cnt", ovr_cnt, 1);
        want_q = '{8'h01, 8'h00, 8'h02, 8'h00};
        chk_stream("s4_stream");

        // New result lands on the last-byte handshake with nothing pending.
        cyc(1'b1, 16'hCAFE, 1'b1);
        cyc(1'b0, 16'h0, 1'b1);
        cyc(1'b1, 16'hBEEF, 1'b1);
        repeat (4) cyc(1'b0, 16'h0, 1'b1);
        chk("s5_ovr_cnt", ovr_cnt, 0);
        want_q = '{8'hFE, 8'hCA, 8'hEF, 8'hBE};
        chk_stream("s5_stream");

        // Reset mid-transfer with a result pending.
        cyc(1'b1, 16'hDEAD, 1'b0);
        cyc(1'b1, 16'h0BAD, 1'b1);
        chk("pre_rst_busy", {31'b0, BUSY}, 32'h1);
        RST = 1'b1;
        #1;
        chk("mid_rst_data", {24'b0, TX_DATA}, 32'h00);
        chk("mid_rst_vld", {31'b0, TX_VLD}, 32'h0);
        chk("mid_rst_busy", {31'b0, BUSY}, 32'h0);
        chk("mid_rst_ovr", {31'b0, OVERRUN}, 32'h0);
        exp_q.delete();
        exp_ovr = 1'b0;
        got_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        OUT_VALID = 1'b0;
        @(negedge CLK);
        repeat (4) cyc(1'b0, 16'h0, 1'b1);
        want_q.delete();
        chk_stream("post_rst_stream");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) < 40), 16'($urandom), ($urandom_range(0, 99) < 65));
        end
        repeat (8) cyc(1'b0, 16'h0, 1'b1);
        chk("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_packer.md
# alu_result_packer

Downstream stage of the registered ALU result path. Captures each valid ALU result (`ALU_OUT` qualified by its one-cycle `OUT_VALID` flag) and streams it as bytes, LSB first, over a valid/ready byte interface toward the UART TX framing logic. It also holds one pending result so back-to-back ALU operations are not lost while a transfer is in flight, and it flags overrun when a result must be dropped.

## Interface
- `OUT_DATA_WIDTH`, 16: ALU result width. Must be a multiple of 8 and at least 8.
- `BYTES` (localparam), `OUT_DATA_WIDTH/8`: number of bytes per result.
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: asynchronous reset, active-high.
- `ALU_OUT` input OUT_DATA_WIDTH: registered ALU result.
- `OUT_VALID` input 1: one-cycle strobe marking `ALU_OUT` valid.
- `TX_DATA` output 8: byte currently offered.
- `TX_VLD` output 1: `TX_DATA` valid.
- `TX_RDY` input 1: consumer accepts the byte this cycle.
- `BUSY` output 1: high while a transfer is active or a result is pending.
- `OVERRUN` output 1: one-cycle pulse when an incoming result is dropped.

## Operation
- Storage:
  - shift/holding register `cur`.
  - byte counter `idx` over 0..BYTES-1.
  - pending register `pend` with valid bit `pend_v`.
- FSM states:
  - IDLE: `TX_VLD`=0.
  - SEND: `TX_VLD`=1, `TX_DATA` = byte `idx` of `cur` (bits `8*idx+7 : 8*idx`).
- IDLE with `OUT_VALID`=1: load `cur`←`ALU_OUT`, `idx`←0, go to SEND.
- SEND handshake (`TX_VLD & TX_RDY`):
  - If `idx` < BYTES-1: increment `idx`.
  - If `idx` = BYTES-1 (last byte):
    - `pend_v`=1: load `cur`←`pend`, clear `pend_v`, `idx`←0, stay in SEND.
    - Else if `OUT_VALID`=1 this cycle: load `cur`←`ALU_OUT` directly, `idx`←0, stay in SEND.
    - Else: go to IDLE.
- SEND with `OUT_VALID`=1 that is not consumed by the last-byte case above:
  - If `pend_v`=0: `pend`←`ALU_OUT`, set `pend_v`.
  - If `pend_v`=1 and a last-byte handshake occurs this cycle: `pend` moves to `cur` and the new result is written to `pend`; `pend_v` stays 1 and no overrun.
  - If `pend_v`=1 and no last-byte handshake: drop the new result, pulse `OVERRUN` for one cycle. `cur` and `pend` are unchanged.
- `TX_DATA` and `TX_VLD` stay stable while `TX_VLD`=1 and `TX_RDY`=0.
- `TX_RDY` is ignored when `TX_VLD`=0.
- `BUSY` = (state == SEND) | `pend_v`.
- Reset at any time, including mid-transfer, aborts the transfer and discards `pend`. No partial result is resumed.

## Timing
- Reset values:
  - `TX_DATA`=8'h00, `TX_VLD`=0, `BUSY`=0, `OVERRUN`=0.
  - State IDLE, `idx`=0, `pend_v`=0, `cur`=0, `pend`=0.
- All outputs are registered, or decoded only from registered state.
- Latency: `OUT_VALID` at cycle N gives `TX_VLD`=1 with byte 0 at cycle N+1.
- With `TX_RDY` held high, a result occupies exactly BYTES cycles.
- Back-to-back results with `TX_RDY`=1 stream with no idle gap between the last byte of one result and byte 0 of the next.
- `OVERRUN` is asserted in the cycle after the dropping `OUT_VALID`.

## Test plan
- Reset then `ALU_OUT`=16'hA55A with `OUT_VALID` pulse, `TX_RDY`=1 -> `TX_DATA` 8'h5A then 8'hA5 on consecutive cycles, then `TX_VLD`=0 and `BUSY`=0.
- Same transfer with `TX_RDY`=0 for 3 cycles after byte 0 appears -> 8'h5A held stable for 4 cycles, then 8'hA5; no byte duplicated or skipped.
- `OUT_VALID` with 16'h1234 then 16'h5678 one cycle later, `TX_RDY`=1 -> byte stream 34, 12, 78, 56 with no gap; `OVERRUN` never asserted.
- Three `OUT_VALID` pulses (16'h0001, 16'h0002, 16'h0003) on consecutive cycles with `TX_RDY`=0 -> `OVERRUN` pulses once for 16'h0003. After releasing `TX_RDY`: stream 01, 00, 02, 00.
- `OUT_VALID` with 16'hBEEF coinciding with the last-byte handshake of 16'hCAFE while pending is empty -> stream FE, CA, EF, BE contiguous.
- Assert `RST` after byte 0 of 16'hDEAD has been accepted, with 16'h0BAD pending -> all outputs return to their reset values immediately. After release, no bytes are emitted until a new `OUT_VALID`.
